// File: rtl/risc_trace_pkg.sv
// Shared definitions for the Risc retire-trace monitor.
//
// Contents:
//   state_t     - run-control state encoding (RUN, HALTED, TIMEDOUT, DUMP, DRAINED)
//   OPC_NOP     - opcode field value treated as a NOP by the optional filter
//   OPC_MSB/LSB - position of the opcode field inside an instruction word
//   ENTRY_W     - width of one trace entry {pc, inst} for the default word size
//   is_nop_opc  - helper that classifies an opcode field
package risc_trace_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_HALTED   = 3'd1,
    ST_TIMEDOUT = 3'd2,
    ST_DUMP     = 3'd3,
    ST_DRAINED  = 3'd4
  } state_t;

  localparam logic [6:0] OPC_NOP = 7'b0000000;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 25;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ENTRY_W = 2 * DATA_WIDTH_DEF;

  function automatic logic is_nop_opc(input logic [6:0] opc);
    return (opc == OPC_NOP);
  endfunction

endpackage

// File: rtl/trace_ring_buf.sv
// Circular trace store that keeps the most recent DEPTH entries.
//
// Writes always succeed: once the buffer is full a write replaces the oldest
// entry and raises the sticky overflow flag. Reading is a separate walk:
// start_rd points the read pointer at the oldest entry, pop advances it.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset (pointers only;
//                   the storage array itself is never reset)
//   push          - write push_data at the write pointer
//   push_data     - entry to store
//   start_rd      - load read pointer with the oldest entry (wr_ptr - count)
//   pop           - advance read pointer by one
//   rd_data       - entry at the read pointer
//   rd_is_newest  - read pointer sits on the most recently written entry
//   empty         - no entries stored
//   overflow      - sticky: at least one entry has been overwritten
module trace_ring_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             start_rd,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_is_newest,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (count == FULL) begin
          ovf_q <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end
      // When full, count[AW-1:0] is zero so the oldest entry is at wr_ptr.
      if (start_rd) begin
        rd_ptr <= wr_ptr - count[AW-1:0];
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign rd_data      = mem[rd_ptr];
  assign rd_is_newest = (rd_ptr == (wr_ptr - PTR_ONE));
  assign empty        = (count == '0);
  assign overflow     = ovf_q;

endmodule

// File: rtl/risc_trace_monitor.sv
// Run-control and retire-trace monitor for the Risc core.
//
// While the core runs, the monitor counts cycles and retires, records every
// retire into a circular trace buffer and runs a watchdog. The run ends on
// halt (run_done) or on watchdog expiry (timeout); afterwards a dump_req
// streams the buffer oldest-first and the block parks in DRAINED until reset.
//
// Optional build macro: TRACE_NOP_FILTER_EN
//   defined   - retires whose opcode field inst_wb[31:25] is 7'b0000000 are
//               neither stored nor counted (they still feed the watchdog)
//   undefined - every retire is stored and counted
// With the filter present DATA_WIDTH must be at least 32.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   halt          - core halt level
//   wb_valid      - one instruction retires this cycle
//   pc_wb/inst_wb - PC and instruction word of the retiring instruction
//   dump_req      - single-cycle pulse requesting the buffer dump
//   dump_valid/dump_ready/dump_data/dump_last - dump stream, {pc, inst}
//   run_done      - run ended by halt
//   timeout       - run ended by watchdog
//   overflow      - sticky: trace buffer overwrote at least one entry
//   cycle_count   - cycles spent in RUN (saturating)
//   retire_count  - instructions recorded (saturating)
//   state_dbg     - current FSM state
module risc_trace_monitor
  import risc_trace_pkg::*;
#(
  parameter int DATA_WIDTH  = ENTRY_W / 2,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int WDOG_LIMIT  = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    halt,
  input  logic                    wb_valid,
  input  logic [DATA_WIDTH-1:0]   pc_wb,
  input  logic [DATA_WIDTH-1:0]   inst_wb,
  input  logic                    dump_req,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [2*DATA_WIDTH-1:0] dump_data,
  output logic                    dump_last,
  output logic                    run_done,
  output logic                    timeout,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    cycle_count,
  output logic [CNT_WIDTH-1:0]    retire_count,
  output state_t                  state_dbg
);

  localparam int EW     = 2 * DATA_WIDTH;
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [WDOG_W-1:0]    WDOG_ONE  = WDOG_W'(1);
  localparam logic [WDOG_W-1:0]    WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

`ifdef TRACE_NOP_FILTER_EN
  localparam bit NOP_FILTER = 1'b1;
`else
  localparam bit NOP_FILTER = 1'b0;
`endif

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] cycle_q, retire_q;
  logic [WDOG_W-1:0]    wdog_q;
  logic                 run_done_q, timeout_q;

  logic                 dump_valid_q, dump_last_q;
  logic [EW-1:0]        dump_data_q;

  logic                 is_nop, record, wdog_expire;
  logic                 rb_push, rb_start_rd, rb_pop;
  logic [EW-1:0]        rb_rd_data;
  logic                 rb_rd_is_newest, rb_empty, rb_overflow;
  logic                 load_entry, drain;

  assign is_nop      = is_nop_opc(inst_wb[OPC_MSB:OPC_LSB]);
  assign record      = wb_valid && !(NOP_FILTER && is_nop);
  // A retire in the expiry cycle restarts the watchdog, so it cannot expire.
  assign wdog_expire = !wb_valid && (wdog_q == WDOG_LAST);
  assign rb_push     = (state_q == ST_RUN) && record;

  trace_ring_buf #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (EW)
  ) u_ring (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (rb_push),
    .push_data    ({pc_wb, inst_wb}),
    .start_rd     (rb_start_rd),
    .pop          (rb_pop),
    .rd_data      (rb_rd_data),
    .rd_is_newest (rb_rd_is_newest),
    .empty        (rb_empty),
    .overflow     (rb_overflow)
  );

  // Dump handshake: an entry transfers on a rising edge where dump_valid and
  // dump_ready are both 1. While dump_valid=1 and dump_ready=0, dump_data and
  // dump_last hold. dump_valid never drops without a transfer; it drops only
  // after the transfer of the entry carrying dump_last.
  always_comb begin
    state_d     = state_q;
    rb_start_rd = 1'b0;
    rb_pop      = 1'b0;
    load_entry  = 1'b0;
    drain       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (wdog_expire) begin
          state_d = ST_TIMEDOUT;
        end
      end
      ST_HALTED, ST_TIMEDOUT: begin
        if (dump_req) begin
          if (rb_empty) begin
            state_d = ST_DRAINED;
          end else begin
            state_d     = ST_DUMP;
            rb_start_rd = 1'b1;
          end
        end
      end
      ST_DUMP: begin
        // Output slot is free on the first DUMP cycle or after a transfer.
        if (!dump_valid_q || dump_ready) begin
          if (dump_valid_q && dump_last_q) begin
            state_d = ST_DRAINED;
            drain   = 1'b1;
          end else begin
            load_entry = 1'b1;
            rb_pop     = 1'b1;
          end
        end
      end
      ST_DRAINED: begin
        state_d = ST_DRAINED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and run-end flags only move in RUN; they freeze afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q    <= '0;
      retire_q   <= '0;
      wdog_q     <= '0;
      run_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (cycle_q != '1) begin
        cycle_q <= cycle_q + CNT_ONE;
      end
      if (record && (retire_q != '1)) begin
        retire_q <= retire_q + CNT_ONE;
      end
      if (wb_valid) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + WDOG_ONE;
      end
      if (halt) begin
        run_done_q <= 1'b1;
      end else if (wdog_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_valid_q <= 1'b0;
      dump_last_q  <= 1'b0;
      dump_data_q  <= '0;
    end else if (load_entry) begin
      dump_valid_q <= 1'b1;
      dump_last_q  <= rb_rd_is_newest;
      dump_data_q  <= rb_rd_data;
    end else if (drain) begin
      dump_valid_q <= 1'b0;
      dump_last_q  <= 1'b0;
    end
  end

  assign dump_valid   = dump_valid_q;
  assign dump_data    = dump_data_q;
  assign dump_last    = dump_last_q;
  assign run_done     = run_done_q;
  assign timeout      = timeout_q;
  assign overflow     = rb_overflow;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign state_dbg    = state_q;

endmodule
